// File: rtl/morse_keyer.sv
// Morse output stage: FWFT word FIFO feeding a unit-timed keyer FSM.
// Words carry a symbol count in [15:12] and dash/dot symbols MSB-first in [11:0].
module morse_keyer #(
  parameter int unsigned UNIT_CYCLES = 5_000_000,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned ADR_WIDTH   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [15:0]          in_data,
  output logic                 in_ready,
  input  logic                 auto_mode,
  input  logic                 send,
  output logic                 key_out,
  output logic                 busy,
  output logic [15:0]          led_code,
  output logic                 empty,
  output logic                 full,
  output logic [ADR_WIDTH:0]   count
);

  localparam int unsigned TW = $clog2(UNIT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    SPACE,
    CGAP,
    WGAP
  } state_t;

  logic [15:0]          mem [DEPTH];
  logic [ADR_WIDTH-1:0] wr_ptr;
  logic [ADR_WIDTH-1:0] rd_ptr;
  logic                 push;
  logic                 pop;
  logic [15:0]          head;
  logic [3:0]           head_len;

  state_t      state;
  state_t      state_next;
  logic [TW-1:0] tmr;
  logic [2:0]  units;
  logic [2:0]  units_target;
  logic        tick;
  logic        done;
  logic [11:0] shreg;
  logic [3:0]  sym_left;
  logic        pending;
  logic        key_next;
  logic        busy_next;

  // FIFO (first-word-fall-through)
  assign head     = mem[rd_ptr];
  assign head_len = (head[15:12] > 4'd12) ? 4'd12 : head[15:12];
  assign empty    = (count == '0);
  assign full     = (count == (ADR_WIDTH+1)'(DEPTH));
  assign in_ready = ~full & ~rst;
  assign push     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Unit timing: each state lasts units_target whole units
  always_comb begin
    units_target = 3'd1;
    case (state)
      MARK:    units_target = shreg[11] ? 3'd3 : 3'd1;
      SPACE:   units_target = 3'd1;
      CGAP:    units_target = 3'd3;
      WGAP:    units_target = 3'd4;
      default: units_target = 3'd1;
    endcase
  end

  assign tick = (tmr == TW'(UNIT_CYCLES - 1));
  assign done = tick && (units == units_target - 3'd1);

  // State register with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      key_out <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      key_out <= key_next;
      busy    <= busy_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = (head_len == 4'd0) ? WGAP : MARK;
      MARK:    if (done) state_next = (sym_left == 4'd1) ? CGAP : SPACE;
      SPACE:   if (done) state_next = MARK;
      CGAP:    if (done) state_next = IDLE;
      WGAP:    if (done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control logic
  always_comb begin
    pop       = 1'b0;
    key_next  = 1'b0;
    busy_next = 1'b0;
    if (state == IDLE && !empty && (auto_mode || pending)) begin
      pop = 1'b1;
    end
    key_next  = (state_next == MARK);
    busy_next = (state_next != IDLE);
  end

  // Datapath: timer, symbol shifter, pending request, displayed word
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr      <= '0;
      units    <= '0;
      shreg    <= '0;
      sym_left <= '0;
      pending  <= 1'b0;
      led_code <= '0;
    end else begin
      if (state_next != state || state == IDLE) begin
        tmr   <= '0;
        units <= '0;
      end else if (tick) begin
        tmr   <= '0;
        units <= units + 3'd1;
      end else begin
        tmr <= tmr + 1'b1;
      end

      if (pop) begin
        shreg    <= head[11:0];
        sym_left <= head_len;
        led_code <= head;
        pending  <= 1'b0;
      end else if (send && !empty) begin
        pending <= 1'b1;
      end

      if (state == MARK && done) begin
        shreg    <= {shreg[10:0], 1'b0};
        sym_left <= sym_left - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer with UNIT_CYCLES=4, DEPTH=4.
module tb_morse_keyer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        auto_mode;
  logic        send;
  logic        key_out;
  logic        busy;
  logic [15:0] led_code;
  logic        empty;
  logic        full;
  logic [2:0]  count;

  morse_keyer #(
    .UNIT_CYCLES(4),
    .DEPTH(4),
    .ADR_WIDTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .auto_mode(auto_mode),
    .send(send),
    .key_out(key_out),
    .busy(busy),
    .led_code(led_code),
    .empty(empty),
    .full(full),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        key_hist[$];
  logic        busy_hist[$];
  int          count_hist[$];
  logic [15:0] led_seq[$];
  int          exp_q[$];

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        s;
    logic        rdy;
    logic        fl;
    logic        em;
    int          cnt;
    logic        key;
    logic        bsy;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_hist();
    key_hist.delete();
    busy_hist.delete();
    count_hist.delete();
    led_seq.delete();
  endtask

  task automatic cyc(input logic v, input logic [15:0] d, input logic s);
    in_valid = v;
    in_data  = d;
    send     = s;
    @(posedge clk);
    #1;
    key_hist.push_back(key_out);
    busy_hist.push_back(busy);
    count_hist.push_back(int'(count));
    if (led_seq.size() == 0 || led_seq[$] != led_code) led_seq.push_back(led_code);
    in_valid = 1'b0;
    send     = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    send     = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_hist();
  endtask

  // Compare run lengths of key_out (which=0) or busy (which=1) against exp_q
  task automatic check_runs(input string name, input logic which, input logic first);
    int   r[$];
    logic cur;
    int   len;
    int   sz;
    logic b;
    sz = which ? busy_hist.size() : key_hist.size();
    cur = 1'b0;
    len = 0;
    for (int i = 0; i < sz; i++) begin
      b = which ? busy_hist[i] : key_hist[i];
      if (i == 0) begin
        cur = b;
        len = 1;
      end else if (b === cur) begin
        len++;
      end else begin
        r.push_back(len);
        cur = b;
        len = 1;
      end
    end
    if (sz > 0) r.push_back(len);
    chk($sformatf("%s first", name), (which ? busy_hist[0] : key_hist[0]), first);
    chk($sformatf("%s nruns", name), r.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < r.size(); j++)
      chk($sformatf("%s run%0d", name, j), r[j], exp_q[j]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    auto_mode = 1'b0;
    send      = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst key_out", key_out, 0);
    chk("rst busy", busy, 0);
    chk("rst led_code", led_code, 0);
    chk("rst empty", empty, 1);
    chk("rst full", full, 0);
    chk("rst count", count, 0);
    chk("rst in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", in_ready, 1);

    // 1: 'A' in auto mode: dot, space, dash, char gap
    do_reset();
    auto_mode = 1'b1;
    cyc(1'b1, 16'h2400, 1'b0);
    idle(40);
    exp_q = '{1, 4, 4, 12, 20};
    check_runs("t1 key", 1'b0, 1'b0);
    exp_q = '{1, 32, 8};
    check_runs("t1 busy", 1'b1, 1'b0);
    chk("t1 led_code", led_code, 16'h2400);
    chk("t1 count", count, 0);

    // 2: manual mode, stalled until send; a send during busy queues the next char
    do_reset();
    auto_mode = 1'b0;
    cyc(1'b1, 16'h1000, 1'b0);
    cyc(1'b1, 16'h1000, 1'b0);
    idle(10);
    exp_q = '{12};
    check_runs("t2 stall key", 1'b0, 1'b0);
    chk("t2 stall count", count, 2);
    clear_hist();
    for (int unsigned i = 0; i < 40; i++) cyc(1'b0, 16'h0000, (i == 0 || i == 8));
    exp_q = '{1, 4, 13, 4, 18};
    check_runs("t2 key", 1'b0, 1'b0);
    exp_q = '{1, 16, 1, 16, 6};
    check_runs("t2 busy", 1'b1, 1'b0);
    chk("t2 count mid", count_hist[10], 1);
    chk("t2 count end", count, 0);

    // 3: E, word gap, E; low gap = CGAP(12) + idle(1) + WGAP(16) + idle(1)
    do_reset();
    auto_mode = 1'b1;
    cyc(1'b1, 16'h1000, 1'b0);
    cyc(1'b1, 16'h0000, 1'b0);
    cyc(1'b1, 16'h1000, 1'b0);
    idle(57);
    exp_q = '{1, 4, 30, 4, 21};
    check_runs("t3 key", 1'b0, 1'b0);
    exp_q = '{1, 16, 1, 16, 1, 16, 9};
    check_runs("t3 busy", 1'b1, 1'b0);

    // 4: fill, overflow attempt, send while full, then drain in order
    do_reset();
    auto_mode = 1'b0;
    tbl[0] = '{1'b1, 16'h1000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 16'h2000, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 16'h1800, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 16'h2800, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 16'h2400, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 16'h2400, 1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 16'h2400, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 16'h2400, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b1};
    for (int unsigned i = 0; i < 9; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].s);
      chk($sformatf("t4[%0d] in_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("t4[%0d] full", i), full, tbl[i].fl);
      chk($sformatf("t4[%0d] empty", i), empty, tbl[i].em);
      chk($sformatf("t4[%0d] count", i), count, tbl[i].cnt);
      chk($sformatf("t4[%0d] key_out", i), key_out, tbl[i].key);
      chk($sformatf("t4[%0d] busy", i), busy, tbl[i].bsy);
    end
    auto_mode = 1'b1;
    idle(160);
    chk("t4 led nseq", led_seq.size(), 6);
    if (led_seq.size() == 6) begin
      chk("t4 led seq0", led_seq[0], 16'h0000);
      chk("t4 led seq1", led_seq[1], 16'h1000);
      chk("t4 led seq2", led_seq[2], 16'h2000);
      chk("t4 led seq3", led_seq[3], 16'h1800);
      chk("t4 led seq4", led_seq[4], 16'h2800);
      chk("t4 led seq5", led_seq[5], 16'h2400);
    end
    chk("t4 drained count", count, 0);
    chk("t4 drained empty", empty, 1);

    // 5: reset in the middle of a dash discards everything
    do_reset();
    auto_mode = 1'b1;
    cyc(1'b1, 16'h1800, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0);
    cyc(1'b1, 16'h1000, 1'b0);
    idle(3);
    chk("t5 mid-dash key", key_out, 1);
    chk("t5 mid-dash count", count, 1);
    rst = 1'b1;
    cyc(1'b0, 16'h0000, 1'b0);
    chk("t5 abort key", key_out, 0);
    chk("t5 abort busy", busy, 0);
    chk("t5 abort count", count, 0);
    chk("t5 abort empty", empty, 1);
    rst = 1'b0;
    clear_hist();
    cyc(1'b1, 16'h1000, 1'b0);
    idle(29);
    exp_q = '{1, 4, 25};
    check_runs("t5 key", 1'b0, 1'b0);
    exp_q = '{1, 16, 13};
    check_runs("t5 busy", 1'b1, 1'b0);

    // 6: L=15 clamps to 12 dots
    do_reset();
    auto_mode = 1'b1;
    cyc(1'b1, 16'hF000, 1'b0);
    idle(109);
    exp_q.delete();
    exp_q.push_back(1);
    for (int unsigned i = 0; i < 11; i++) begin
      exp_q.push_back(4);
      exp_q.push_back(4);
    end
    exp_q.push_back(4);
    exp_q.push_back(17);
    check_runs("t6 key", 1'b0, 1'b0);
    exp_q = '{1, 104, 5};
    check_runs("t6 busy", 1'b1, 1'b0);
    chk("t6 led_code", led_code, 16'hF000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
